// File: rtl/mips_cpu_hilo_pkg.sv
// ---------------------------------------------------------------------------
// mips_cpu_hilo_pkg
// Shared definitions for the HI/LO multiply/divide path:
//   - funct field encodings of the HI/LO-class instructions
//   - state encoding of the CPU-side HI/LO controller
// ---------------------------------------------------------------------------
package mips_cpu_hilo_pkg;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        MUL,
        DIV_START,
        DIV_WAIT,
        DIV_WB
    } hilo_ctrl_state_t;

endpackage

// File: rtl/mips_cpu_hilo_ctrl.sv
// ---------------------------------------------------------------------------
// mips_cpu_hilo_ctrl
// CPU-side initiator for the HI/LO multiply/divide unit. Accepts decoded
// HI/LO-class instructions, drives opcode/operands (and the divide start
// pulse) to the unit, holds the opcode for as long as the unit needs it,
// stalls the pipeline while busy and returns mfhi/mflo results.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   instr_valid     : decode presents a HI/LO-class instruction
//   funct           : instruction funct field
//   rs_val, rt_val  : operands (latched at acceptance)
//   stall           : pipeline must hold the current instruction
//   rd_data/rd_valid: mfhi/mflo result and its one-cycle valid pulse
//   err_timeout     : one-cycle pulse when a divide is abandoned
//   hl_opcode/hl_a/hl_b/hl_valid_in : request side to the HI/LO unit
//   hl_valid_out/hl_hi/hl_lo        : completion and HI/LO from the unit
// ---------------------------------------------------------------------------
module mips_cpu_hilo_ctrl
    import mips_cpu_hilo_pkg::*;
#(
    parameter int         MULT_CYCLES = 2,
    parameter int         DIV_TIMEOUT = 40,
    parameter logic [5:0] NOP_OPCODE  = 6'b000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        err_timeout,
    output logic [5:0]  hl_opcode,
    output logic [31:0] hl_a,
    output logic [31:0] hl_b,
    output logic        hl_valid_in,
    input  logic        hl_valid_out,
    input  logic [31:0] hl_hi,
    input  logic [31:0] hl_lo
);

    localparam int CW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
    localparam int TW = $clog2(DIV_TIMEOUT + 1);

    hilo_ctrl_state_t state_q, state_d;
    logic [5:0]       hl_opcode_q, hl_opcode_d;
    logic [31:0]      hl_a_q, hl_a_d;
    logic [31:0]      hl_b_q, hl_b_d;
    logic             hl_valid_in_q, hl_valid_in_d;
    logic             stall_q, stall_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             err_timeout_q, err_timeout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;

    always_comb begin
        state_d       = state_q;
        hl_opcode_d   = hl_opcode_q;
        hl_a_d        = hl_a_q;
        hl_b_d        = hl_b_q;
        hl_valid_in_d = 1'b0;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
        err_timeout_d = 1'b0;
        cnt_d         = cnt_q;
        tcnt_d        = tcnt_q;

        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    case (funct)
                        FN_MFHI: begin
                            rd_data_d  = hl_hi;
                            rd_valid_d = 1'b1;
                        end
                        FN_MFLO: begin
                            rd_data_d  = hl_lo;
                            rd_valid_d = 1'b1;
                        end
                        FN_MTHI, FN_MTLO: begin
                            hl_opcode_d = funct;
                            hl_a_d      = rs_val;
                            state_d     = MOVE;
                        end
                        FN_MULT, FN_MULTU: begin
                            hl_opcode_d = funct;
                            hl_a_d      = rs_val;
                            hl_b_d      = rt_val;
                            cnt_d       = CW'(MULT_CYCLES - 1);
                            state_d     = MUL;
                        end
                        FN_DIV, FN_DIVU: begin
                            hl_opcode_d   = funct;
                            hl_a_d        = rs_val;
                            hl_b_d        = rt_val;
                            hl_valid_in_d = 1'b1;
                            state_d       = DIV_START;
                        end
                        default: ; // not a HI/LO instruction: ignore
                    endcase
                end
            end
            MOVE: begin
                hl_opcode_d = NOP_OPCODE;
                state_d     = IDLE;
            end
            MUL: begin
                // Opcode held until the count expires: MULT_CYCLES cycles total.
                if (cnt_q == '0) begin
                    hl_opcode_d = NOP_OPCODE;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV_START: begin
                tcnt_d  = '0;
                state_d = DIV_WAIT;
            end
            DIV_WAIT: begin
                // Completion has priority over a coincident timeout.
                if (hl_valid_out) begin
                    state_d = DIV_WB;
                end else if (tcnt_q == TW'(DIV_TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    hl_opcode_d   = NOP_OPCODE;
                    state_d       = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            DIV_WB: begin
                // Opcode stayed on the unit for one extra cycle to commit HI/LO.
                hl_opcode_d = NOP_OPCODE;
                state_d     = IDLE;
            end
            default: begin
                hl_opcode_d = NOP_OPCODE;
                state_d     = IDLE;
            end
        endcase

        stall_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            hl_opcode_q   <= NOP_OPCODE;
            hl_a_q        <= '0;
            hl_b_q        <= '0;
            hl_valid_in_q <= 1'b0;
            stall_q       <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            cnt_q         <= '0;
            tcnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            hl_opcode_q   <= hl_opcode_d;
            hl_a_q        <= hl_a_d;
            hl_b_q        <= hl_b_d;
            hl_valid_in_q <= hl_valid_in_d;
            stall_q       <= stall_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            err_timeout_q <= err_timeout_d;
            cnt_q         <= cnt_d;
            tcnt_q        <= tcnt_d;
        end
    end

    assign stall       = stall_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign err_timeout = err_timeout_q;
    assign hl_opcode   = hl_opcode_q;
    assign hl_a        = hl_a_q;
    assign hl_b        = hl_b_q;
    assign hl_valid_in = hl_valid_in_q;

endmodule

// File: tb/tb_mips_cpu_hilo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_cpu_hilo_ctrl
// Directed bench for mips_cpu_hilo_ctrl with a behavioural stub HI/LO unit.
// The stub raises hl_valid_out DIV_LAT cycles after a divide start (unless
// no_resp is set) and writes HI/LO while a move/multiply opcode is present.
// ---------------------------------------------------------------------------
module tb_mips_cpu_hilo_ctrl;
    import mips_cpu_hilo_pkg::*;

    localparam int DIV_LAT = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [5:0]  funct;
    logic [31:0] rs_val, rt_val;
    logic        stall, rd_valid, err_timeout, hl_valid_in, hl_valid_out;
    logic [31:0] rd_data, hl_a, hl_b, hl_hi, hl_lo;
    logic [5:0]  hl_opcode;
    logic        no_resp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_cpu_hilo_ctrl #(.MULT_CYCLES(2), .DIV_TIMEOUT(40), .NOP_OPCODE(6'b000000)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .funct(funct),
        .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .rd_data(rd_data),
        .rd_valid(rd_valid), .err_timeout(err_timeout), .hl_opcode(hl_opcode),
        .hl_a(hl_a), .hl_b(hl_b), .hl_valid_in(hl_valid_in),
        .hl_valid_out(hl_valid_out), .hl_hi(hl_hi), .hl_lo(hl_lo)
    );

    // ---------------- stub HI/LO unit ----------------
    logic [63:0]        prod_s, prod_u;
    logic signed [31:0] sa, sb;
    logic [3:0]         dcnt;
    assign prod_s = {{32{hl_a[31]}}, hl_a} * {{32{hl_b[31]}}, hl_b};
    assign prod_u = {32'b0, hl_a} * {32'b0, hl_b};
    assign sa = hl_a;
    assign sb = hl_b;

    always @(posedge clk) begin
        hl_valid_out <= 1'b0;
        if (reset) begin
            dcnt  <= '0;
            hl_hi <= '0;
            hl_lo <= '0;
        end else begin
            case (hl_opcode)
                FN_MTHI:  hl_hi <= hl_a;
                FN_MTLO:  hl_lo <= hl_a;
                FN_MULT:  {hl_hi, hl_lo} <= prod_s;
                FN_MULTU: {hl_hi, hl_lo} <= prod_u;
                default: ;
            endcase
            if (hl_valid_in) begin
                dcnt <= 4'(DIV_LAT);
            end else if (dcnt != 0) begin
                dcnt <= dcnt - 1'b1;
                if (dcnt == 1 && !no_resp) begin
                    hl_valid_out <= 1'b1;
                    if (hl_b != 0) begin
                        if (hl_opcode == FN_DIV) begin
                            hl_lo <= sa / sb;
                            hl_hi <= sa % sb;
                        end else begin
                            hl_lo <= hl_a / hl_b;
                            hl_hi <= hl_a % hl_b;
                        end
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        instr_valid = 1'b1;
        funct       = f;
        rs_val      = a;
        rt_val      = b;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic read_hl(input string tag, input logic [5:0] f, input logic [31:0] exp);
        issue(f, 32'h0, 32'h0);
        check({tag, "_valid"}, {31'b0, rd_valid}, 32'd1);
        check({tag, "_data"}, rd_data, exp);
        $display("txn %s rd_data=%h", tag, rd_data);
    endtask

    int n, extra_vin, err_seen, bad;
    bit done;

    initial begin
        reset = 1'b1; instr_valid = 1'b0; funct = '0; rs_val = '0; rt_val = '0; no_resp = 1'b0;
        tick(); tick();
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_opcode", {26'b0, hl_opcode}, 32'd0);
        check("rst_vin", {31'b0, hl_valid_in}, 32'd0);
        check("rst_rdv", {31'b0, rd_valid}, 32'd0);
        check("rst_rdata", rd_data, 32'd0);
        check("rst_err", {31'b0, err_timeout}, 32'd0);
        check("rst_a", hl_a, 32'd0);
        $display("txn reset");
        reset = 1'b0;
        tick();

        // mthi then mfhi
        issue(FN_MTHI, 32'h12345678, 32'h0);
        check("mthi_stall", {31'b0, stall}, 32'd1);
        check("mthi_opcode", {26'b0, hl_opcode}, {26'b0, FN_MTHI});
        check("mthi_a", hl_a, 32'h12345678);
        tick();
        check("mthi_stall_end", {31'b0, stall}, 32'd0);
        check("mthi_nop", {26'b0, hl_opcode}, 32'd0);
        $display("txn mthi a=%h", hl_a);
        read_hl("mfhi1", FN_MFHI, 32'h12345678);
        tick();
        check("rdv_pulse", {31'b0, rd_valid}, 32'd0);

        // multu
        issue(FN_MULTU, 32'h00010000, 32'h00010000);
        check("mul_stall1", {31'b0, stall}, 32'd1);
        check("mul_opcode", {26'b0, hl_opcode}, {26'b0, FN_MULTU});
        check("mul_b", hl_b, 32'h00010000);
        tick();
        check("mul_stall2", {31'b0, stall}, 32'd1);
        tick();
        check("mul_stall_end", {31'b0, stall}, 32'd0);
        check("mul_nop", {26'b0, hl_opcode}, 32'd0);
        $display("txn multu");
        read_hl("mul_hi", FN_MFHI, 32'h00000001);
        read_hl("mul_lo", FN_MFLO, 32'h00000000);

        // signed div -7 / 2
        issue(FN_DIV, 32'hFFFFFFF9, 32'd2);
        check("div_vin", {31'b0, hl_valid_in}, 32'd1);
        check("div_stall", {31'b0, stall}, 32'd1);
        n = 1; extra_vin = 0; err_seen = 0; done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            if (hl_valid_in) extra_vin++;
            if (err_timeout) err_seen++;
            if (!stall) done = 1;
            else n++;
        end
        check("div_done", {31'b0, done}, 32'd1);
        check("div_stall_len", n, 32'd9);
        check("div_vin_once", extra_vin, 32'd0);
        check("div_no_err", err_seen, 32'd0);
        check("div_nop", {26'b0, hl_opcode}, 32'd0);
        $display("txn div stall_cycles=%0d", n);
        read_hl("div_lo", FN_MFLO, 32'hFFFFFFFD);
        read_hl("div_hi", FN_MFHI, 32'hFFFFFFFF);

        // divu 100/7 with mflo waiting during busy, operands disturbed
        issue(FN_DIVU, 32'd100, 32'd7);
        instr_valid = 1'b1; funct = FN_MFLO; rs_val = 32'hDEADBEEF; rt_val = 32'hCAFEF00D;
        tick();
        n = 1;
        check("divu_a_hold", hl_a, 32'd100);
        check("divu_b_hold", hl_b, 32'd7);
        check("divu_stall", {31'b0, stall}, 32'd1);
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            n++;
            if (rd_valid) done = 1;
        end
        instr_valid = 1'b0;
        check("divu_rdv", {31'b0, done}, 32'd1);
        check("divu_wait", n, 32'd10);
        check("divu_lo", rd_data, 32'h0000000E);
        $display("txn divu mflo=%h after %0d cycles", rd_data, n);
        read_hl("divu_hi", FN_MFHI, 32'h00000002);

        // reset 5 cycles into divu
        issue(FN_DIVU, 32'd100, 32'd7);
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        check("rmid_stall", {31'b0, stall}, 32'd0);
        check("rmid_opcode", {26'b0, hl_opcode}, 32'd0);
        check("rmid_vin", {31'b0, hl_valid_in}, 32'd0);
        check("rmid_rdv", {31'b0, rd_valid}, 32'd0);
        check("rmid_err", {31'b0, err_timeout}, 32'd0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rd_valid || err_timeout || stall || hl_valid_in) bad++;
        end
        check("rmid_quiet", bad, 32'd0);
        $display("txn reset_mid_divu");

        // unknown funct ignored
        issue(6'b100000, 32'h1, 32'h2);
        check("unk_stall", {31'b0, stall}, 32'd0);
        check("unk_rdv", {31'b0, rd_valid}, 32'd0);
        check("unk_opcode", {26'b0, hl_opcode}, 32'd0);
        $display("txn unknown_funct");

        // divide timeout
        no_resp = 1'b1;
        issue(FN_DIVU, 32'd9, 32'd0);
        done = 0; n = 0;
        for (int i = 1; i <= 100 && !done; i++) begin
            tick();
            if (err_timeout) begin
                done = 1;
                n = i;
            end
        end
        check("to_seen", {31'b0, done}, 32'd1);
        check("to_cycle", n, 32'd41);
        check("to_stall", {31'b0, stall}, 32'd0);
        check("to_nop", {26'b0, hl_opcode}, 32'd0);
        check("to_rdv", {31'b0, rd_valid}, 32'd0);
        tick();
        check("to_pulse", {31'b0, err_timeout}, 32'd0);
        $display("txn divu_timeout at cycle %0d", n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
